// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer for the pixel array: erase/expose/convert phases with run-time
// durations, followed by a raster readout with a valid/ready handshake.
module pixel_frame_sequencer #(
    parameter int ROWS  = 4,
    parameter int COLS  = 4,
    parameter int CNT_W = 16
) (
    input  logic                                      clk,
    input  logic                                      reset_n,
    input  logic                                      start,
    input  logic                                      continuous,
    input  logic                                      stop,
    input  logic                                      abort,
    input  logic [CNT_W-1:0]                          t_erase,
    input  logic [CNT_W-1:0]                          t_expose,
    input  logic [CNT_W-1:0]                          t_convert,
    output logic                                      erase,
    output logic                                      expose,
    output logic                                      convert,
    output logic                                      rd_valid,
    input  logic                                      rd_ready,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] row_addr,
    output logic [((COLS > 1) ? $clog2(COLS) : 1)-1:0] col_addr,
    output logic                                      busy,
    output logic                                      frame_done
);

    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;

    logic [2:0]       state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] t_expose_reg;
    logic [CNT_W-1:0] t_convert_reg;
    logic             cont_reg;
    logic             stop_reg;
    logic             stop_pend;

    // The counter holds remaining cycles minus one, so a zero duration still lasts a cycle.
    function automatic logic [CNT_W-1:0] phase_len(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - CNT_W'(1);
    endfunction

    assign stop_pend = stop_reg | stop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= '0;
            t_expose_reg  <= '0;
            t_convert_reg <= '0;
            cont_reg      <= 1'b0;
            stop_reg      <= 1'b0;
            erase         <= 1'b0;
            expose        <= 1'b0;
            convert       <= 1'b0;
            rd_valid      <= 1'b0;
            row_addr      <= '0;
            col_addr      <= '0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (abort) begin
                state_reg <= S_IDLE;
                cnt_reg   <= '0;
                cont_reg  <= 1'b0;
                stop_reg  <= 1'b0;
                erase     <= 1'b0;
                expose    <= 1'b0;
                convert   <= 1'b0;
                rd_valid  <= 1'b0;
                row_addr  <= '0;
                col_addr  <= '0;
                busy      <= 1'b0;
            end else begin
                if (state_reg != S_IDLE) stop_reg <= stop_pend;
                case (state_reg)
                    S_IDLE: begin
                        if (start) begin
                            state_reg     <= S_ERASE;
                            erase         <= 1'b1;
                            busy          <= 1'b1;
                            cnt_reg       <= phase_len(t_erase);
                            t_expose_reg  <= t_expose;
                            t_convert_reg <= t_convert;
                            cont_reg      <= continuous;
                            stop_reg      <= 1'b0;
                        end
                    end
                    S_ERASE: begin
                        if (cnt_reg == '0) begin
                            state_reg <= S_EXPOSE;
                            erase     <= 1'b0;
                            expose    <= 1'b1;
                            cnt_reg   <= phase_len(t_expose_reg);
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    S_EXPOSE: begin
                        if (cnt_reg == '0) begin
                            state_reg <= S_CONVERT;
                            expose    <= 1'b0;
                            convert   <= 1'b1;
                            cnt_reg   <= phase_len(t_convert_reg);
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    S_CONVERT: begin
                        if (cnt_reg == '0) begin
                            state_reg <= S_READ;
                            convert   <= 1'b0;
                            rd_valid  <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    S_READ: begin
                        if (rd_ready) begin
                            if (col_addr != COL_LAST) begin
                                col_addr <= col_addr + COL_W'(1);
                            end else begin
                                col_addr <= '0;
                                if (row_addr != ROW_LAST) begin
                                    row_addr <= row_addr + ROW_W'(1);
                                end else begin
                                    row_addr   <= '0;
                                    rd_valid   <= 1'b0;
                                    frame_done <= 1'b1;
                                    // A stop seen on this very cycle still ends the loop.
                                    if (cont_reg && !stop_pend) begin
                                        state_reg     <= S_ERASE;
                                        erase         <= 1'b1;
                                        cnt_reg       <= phase_len(t_erase);
                                        t_expose_reg  <= t_expose;
                                        t_convert_reg <= t_convert;
                                    end else begin
                                        state_reg <= S_IDLE;
                                        busy      <= 1'b0;
                                        cont_reg  <= 1'b0;
                                        stop_reg  <= 1'b0;
                                    end
                                end
                            end
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Bench for pixel_frame_sequencer (ROWS=2, COLS=3): frame table, corner sequences and
// random traffic, all checked cycle by cycle against a queue-of-work reference model.
module tb_pixel_frame_sequencer;

    localparam int ROWS = 2;
    localparam int COLS = 3;
    localparam int NPIX = ROWS * COLS;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic             start = 1'b0, continuous = 1'b0, stop = 1'b0, abort = 1'b0;
    logic [CNT_W-1:0] t_erase = '0, t_expose = '0, t_convert = '0;
    logic             erase, expose, convert, rd_valid;
    logic             rd_ready = 1'b0;
    logic             row_addr;
    logic [1:0]       col_addr;
    logic             busy, frame_done;

    int errors = 0;
    int checks = 0;

    // Reference model: a queue of remaining work items, one per phase cycle
    // (1=erase, 2=expose, 3=convert) then one per pixel (100 + raster index).
    int q[$];
    bit m_cont = 0, m_stop = 0, m_done = 0;

    pixel_frame_sequencer #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .continuous(continuous),
        .stop(stop), .abort(abort), .t_erase(t_erase), .t_expose(t_expose),
        .t_convert(t_convert), .erase(erase), .expose(expose), .convert(convert),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .row_addr(row_addr),
        .col_addr(col_addr), .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] dut_vec();
        return {erase, expose, convert, rd_valid, row_addr, col_addr, busy, frame_done};
    endfunction

    function automatic logic [8:0] model_vec();
        int head, pix;
        logic [8:0] v;
        head = (q.size() != 0) ? q[0] : 0;
        pix  = (head >= 100) ? head - 100 : 0;
        v[8] = (head == 1);
        v[7] = (head == 2);
        v[6] = (head == 3);
        v[5] = (head >= 100);
        v[4] = 1'(pix / COLS);
        v[3:2] = 2'(pix % COLS);
        v[1] = (q.size() != 0);
        v[0] = m_done;
        return v;
    endfunction

    task automatic build_frame();
        int te, tx, tc;
        te = (t_erase == 0) ? 1 : int'(t_erase);
        tx = (t_expose == 0) ? 1 : int'(t_expose);
        tc = (t_convert == 0) ? 1 : int'(t_convert);
        repeat (te) q.push_back(1);
        repeat (tx) q.push_back(2);
        repeat (tc) q.push_back(3);
        for (int p = 0; p < NPIX; p++) q.push_back(100 + p);
    endtask

    task automatic model_step(input bit s, input bit c, input bit sp, input bit ab, input bit rr);
        bit dn;
        int head;
        dn = 0;
        if (ab) begin
            q.delete();
            m_cont = 0;
            m_stop = 0;
        end else if (q.size() == 0) begin
            if (s) begin
                build_frame();
                m_cont = c;
                m_stop = 0;
            end
        end else begin
            if (sp) m_stop = 1;
            head = q[0];
            if (head < 100) begin
                void'(q.pop_front());
            end else if (rr) begin
                void'(q.pop_front());
                if (head == 100 + NPIX - 1) begin
                    dn = 1;
                    if (m_cont && !m_stop) build_frame();
                    else begin
                        m_cont = 0;
                        m_stop = 0;
                    end
                end
            end
        end
        m_done = dn;
    endtask

    // Called at a negedge: compare current outputs, drive inputs, advance one clock.
    task automatic tick(input bit s, input bit c, input bit sp, input bit ab, input bit rr);
        check("outputs", 32'(dut_vec()), 32'(model_vec()));
        start = s; continuous = c; stop = sp; abort = ab; rd_ready = rr;
        @(posedge clk);
        model_step(s, c, sp, ab, rr);
        @(negedge clk);
    endtask

    // Idle-input ticks until a condition holds: 1=convert, 2=reading (1,1), 3=frame_done, 4=rd_valid.
    task automatic run_until(input int what, input bit rr);
        bit hit;
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            case (what)
                1: hit = convert;
                2: hit = rd_valid && row_addr == 1'b1 && col_addr == 2'd1;
                3: hit = frame_done;
                default: hit = rd_valid;
            endcase
            if (!hit) tick(0, 0, 0, 0, rr);
        end
        if (!hit) check("timeout", 32'(what), 32'hFFFF);
    endtask

    typedef struct {
        int te, tx, tc;
        int exp_e, exp_x, exp_c, exp_total;
    } vec_t;

    initial begin
        vec_t tbl[4];
        int   acc[$];
        int   ce, cx, cc, cv, cb, nd;
        bit   done, rr, stop_sent;
        bit   pat[4];

        tbl[0] = '{3, 5, 7, 3, 5, 7, 21};
        tbl[1] = '{0, 0, 0, 1, 1, 1, 9};
        tbl[2] = '{0, 4, 1, 1, 4, 1, 12};
        tbl[3] = '{2, 0, 6, 2, 1, 6, 15};
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        check("reset_outputs", 32'(dut_vec()), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Single frames with rd_ready stuck high; inputs scrambled after latching.
        for (int i = 0; i < 4; i++) begin
            t_erase = 16'(tbl[i].te); t_expose = 16'(tbl[i].tx); t_convert = 16'(tbl[i].tc);
            tick(1, 0, 0, 0, 1);
            t_erase = 16'(9); t_expose = 16'(11); t_convert = 16'(2);
            ce = 0; cx = 0; cc = 0; cv = 0; cb = 0; done = 0;
            for (int k = 0; k < 100 && !done; k++) begin
                ce += int'(erase); cx += int'(expose); cc += int'(convert);
                cv += int'(rd_valid); cb += int'(busy);
                if (frame_done) done = 1;
                else tick(0, 0, 0, 0, 1);
            end
            check("frame_done_seen", 32'(done), 32'h1);
            check("erase_cycles", 32'(ce), 32'(tbl[i].exp_e));
            check("expose_cycles", 32'(cx), 32'(tbl[i].exp_x));
            check("convert_cycles", 32'(cc), 32'(tbl[i].exp_c));
            check("read_cycles", 32'(cv), 32'(NPIX));
            check("frame_cycles", 32'(cb), 32'(tbl[i].exp_total));
            $display("frame %0d: t=(%0d,%0d,%0d) busy cycles %0d", i, tbl[i].te, tbl[i].tx, tbl[i].tc, cb);
        end

        // Stalled readout: rd_ready pattern 1,0,0,1 repeating.
        t_erase = 16'(1); t_expose = 16'(1); t_convert = 16'(1);
        tick(1, 0, 0, 0, 0);
        run_until(4, 0);
        done = 0;
        for (int k = 0; k < 100 && !done; k++) begin
            if (frame_done) done = 1;
            else begin
                rr = pat[k % 4];
                if (rd_valid && rr) acc.push_back(int'(row_addr) * COLS + int'(col_addr));
                tick(0, 0, 0, 0, rr);
            end
        end
        check("stall_pixel_count", 32'(acc.size()), 32'(NPIX));
        for (int p = 0; p < acc.size(); p++) check("stall_raster_order", 32'(acc[p]), 32'(p));
        $display("stalled readout: %0d pixels accepted", acc.size());

        // Continuous mode with stop raised during frame 2 expose.
        t_erase = 16'(2); t_expose = 16'(3); t_convert = 16'(2);
        tick(1, 1, 0, 0, 1);
        nd = 0; stop_sent = 0;
        for (int k = 0; k < 80; k++) begin
            if (frame_done) nd++;
            if (nd == 1 && expose && !stop_sent) begin
                stop_sent = 1;
                tick(0, 0, 1, 0, 1);
            end else tick(0, 0, 0, 0, 1);
        end
        check("continuous_done_pulses", 32'(nd), 32'h2);
        check("continuous_idle", 32'(busy), 32'h0);
        $display("continuous with stop: %0d frames", nd);

        // Abort in CONVERT, abort in READ at (1,1), then a clean frame.
        t_erase = 16'(1); t_expose = 16'(1); t_convert = 16'(3);
        tick(1, 0, 0, 0, 1);
        run_until(1, 1);
        tick(0, 0, 0, 1, 1);
        check("abort_convert", 32'(dut_vec()), 32'h0);
        tick(1, 0, 0, 0, 1);
        run_until(2, 1);
        tick(0, 0, 0, 1, 1);
        check("abort_read", 32'(dut_vec()), 32'h0);
        tick(1, 0, 0, 0, 1);
        run_until(3, 1);
        $display("abort sequence complete");

        // Asynchronous reset during READ; start while busy is ignored first.
        tick(1, 0, 0, 0, 0);
        run_until(4, 0);
        tick(1, 1, 0, 0, 0);
        tick(0, 0, 0, 0, 1);
        #2 reset_n = 1'b0;
        #1 check("async_reset", 32'(dut_vec()), 32'h0);
        q.delete(); m_cont = 0; m_stop = 0; m_done = 0;
        @(negedge clk);
        reset_n = 1'b1;
        $display("async reset during read");

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            t_erase   = 16'($urandom_range(0, 4));
            t_expose  = 16'($urandom_range(0, 4));
            t_convert = 16'($urandom_range(0, 4));
            tick($urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 24) == 0,
                 $urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0);
        end
        check("outputs_final", 32'(dut_vec()), 32'(model_vec()));
        $display("random traffic: 3000 cycles");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
